// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported memory request/response channel between
//            the instruction-fetch port and the load/store data port. Only one
//            transaction is outstanding at a time. Data requests win
//            contention, but a starvation counter hands the fetch port one
//            grant after STARVE_MAX consecutive lost arbitrations.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            inst_*                 - fetch requester (req/addr in, ready/rvalid/rdata out)
//            data_*                 - load/store requester (req/wen/addr/wdata/wmask in,
//                                     ready/rvalid/rdata out)
//            mem_req_* / mem_wen /  - request channel to memory (valid/ready handshake)
//            mem_addr/wdata/wmask
//            mem_resp_*             - response channel from memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction-fetch port
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ready,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    // Data (load/store) port
    input  logic              data_req,
    input  logic              data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_wmask,
    output logic              data_ready,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    // Memory channel
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    // Memory is 8-byte word addressed; the low three address bits are dropped.
    localparam logic [ADDR_W-1:0]  c_ALIGN_MASK = ADDR_W'(7);

    logic [1:0]         r_state;
    logic               r_owner_data;   // 1 = data port owns the transaction
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wen;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_wmask;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_inst_ready;
    logic               r_data_ready;
    logic               r_inst_rvalid;
    logic               r_data_rvalid;
    logic [DATA_W-1:0]  r_inst_rdata;
    logic [DATA_W-1:0]  r_data_rdata;

    logic               w_any_req;
    logic               w_data_win;
    logic [ADDR_W-1:0]  w_addr_aligned;

    always_comb begin
        w_any_req      = inst_req | data_req;
        // Data wins any contention except when fetch has hit its starvation limit.
        w_data_win     = data_req & ~(inst_req & (r_starve_cnt == c_STARVE_MAX));
        w_addr_aligned = (w_data_win ? data_addr : inst_addr) & ~c_ALIGN_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_owner_data  <= 1'b0;
            r_addr        <= '0;
            r_wen         <= 1'b0;
            r_wdata       <= '0;
            r_wmask       <= '0;
            r_starve_cnt  <= '0;
            r_inst_ready  <= 1'b0;
            r_data_ready  <= 1'b0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
        end else begin
            // Handshake outputs are single-cycle pulses by default.
            r_inst_ready  <= 1'b0;
            r_data_ready  <= 1'b0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner_data <= w_data_win;
                        r_addr       <= w_addr_aligned;
                        r_state      <= c_REQ;
                        if (w_data_win) begin
                            r_wen        <= data_wen;
                            r_wdata      <= data_wdata;
                            r_wmask      <= data_wmask;
                            r_data_ready <= 1'b1;
                            // Only a grant that actually held off a fetch counts.
                            if (inst_req && (r_starve_cnt != c_STARVE_MAX)) begin
                                r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
                            end
                        end else begin
                            r_wen        <= 1'b0;
                            r_wdata      <= '0;
                            r_wmask      <= '0;
                            r_inst_ready <= 1'b1;
                            r_starve_cnt <= '0;
                        end
                    end
                end

                c_REQ: begin
                    // Any response seen here is stray and is dropped.
                    if (mem_req_ready) begin
                        r_state <= c_WAIT;
                    end
                end

                c_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= c_IDLE;
                        if (r_owner_data) begin
                            r_data_rvalid <= 1'b1;
                            // A store's response is only an acknowledge.
                            if (!r_wen) begin
                                r_data_rdata <= mem_resp_data;
                            end
                        end else begin
                            r_inst_rvalid <= 1'b1;
                            r_inst_rdata  <= mem_resp_data;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign inst_ready    = r_inst_ready;
    assign inst_rvalid   = r_inst_rvalid;
    assign inst_rdata    = r_inst_rdata;
    assign data_ready    = r_data_ready;
    assign data_rvalid   = r_data_rvalid;
    assign data_rdata    = r_data_rdata;
    assign mem_req_valid = (r_state == c_REQ);
    assign mem_wen       = r_wen;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the pipeline's instruction-fetch port and data (load/store) port onto one single-ported memory request/response channel. It sits directly downstream of the core top level, replacing the dual-port RAM hookup. The block owns a three-state FSM, allows one outstanding transaction, and gives data requests priority over fetches. A starvation counter bounds how long a fetch can be held off.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width. Must be 64.
- `STARVE_MAX`, default 4: number of consecutive lost arbitrations after which the fetch port wins once. Must be ≥1.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_req` in 1: fetch request. Held high until `inst_ready`.
- `inst_addr` in ADDR_W: fetch byte address.
- `inst_ready` out 1: one-cycle pulse; fetch request accepted.
- `inst_rvalid` out 1: one-cycle pulse; `inst_rdata` valid.
- `inst_rdata` out 64: 8-byte-aligned memory word.
- `data_req` in 1: load/store request. Held high until `data_ready`.
- `data_wen` in 1: 1 = store, 0 = load.
- `data_addr` in ADDR_W: data byte address.
- `data_wdata` in 64: store data, already lane-shifted by the requester.
- `data_wmask` in 64: bit-level write mask.
- `data_ready` out 1: one-cycle pulse; data request accepted.
- `data_rvalid` out 1: one-cycle pulse; load data valid, or store acknowledge.
- `data_rdata` out 64: load word.
- `mem_req_valid` out 1: request valid to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_wen` out 1: write strobe.
- `mem_addr` out ADDR_W: the requested byte address with bits [2:0] forced to 0.
- `mem_wdata` out 64: write data to memory.
- `mem_wmask` out 64: write mask to memory.
- `mem_resp_valid` in 1: response valid from memory.
- `mem_resp_data` in 64: response data from memory.

## Operation
FSM states are IDLE, REQ and WAIT. Reset state is IDLE.

- **IDLE**, with `inst_req` or `data_req` high:
  - The arbiter selects a winner and latches owner, address, wen, wdata and wmask into registers.
  - It pulses the winner's `*_ready` and goes to REQ.
  - For an instruction winner, `mem_wen` = 0 and `mem_wmask` = 0.
- **IDLE**, with no request: stays in IDLE.
- **Winner selection:**
  - Only one port requesting: that port wins.
  - Both ports requesting: data wins, unless `starve_cnt` == STARVE_MAX, in which case inst wins.
- **REQ:** `mem_req_valid` = 1 and the latched fields drive the `mem_*` outputs. When `mem_req_ready` = 1, drop `mem_req_valid` on the next edge and go to WAIT.
- **WAIT:** when `mem_resp_valid` = 1, register `mem_resp_data` into the owner's `*_rdata`, pulse the owner's `*_rvalid`, and go to IDLE.
  - A store's response data is ignored, but `data_rvalid` still pulses as the acknowledge.
- **starve_cnt:**
  - Width is clog2(STARVE_MAX+1).
  - Increments when data wins while `inst_req` is also high.
  - Clears to 0 when inst wins.
  - Unchanged otherwise. Saturates at STARVE_MAX.
- **Non-owner `*_rdata`:** holds its last value.
- **Stray responses:** `mem_resp_valid` in IDLE or REQ is discarded; no `rvalid` pulse.
- **Reset mid-transaction:** FSM returns to IDLE and `mem_req_valid` deasserts on the next edge. A response arriving later is discarded under the stray-response rule.

## Timing
- **Reset:** every output is 0 on the edge where `rst` = 1 is sampled. This covers all `*_ready`, all `*_rvalid`, all `*_rdata`, and all `mem_*` outputs. `starve_cnt` is also 0.
- **Request path:** request sampled in IDLE at edge N. At N+1, `*_ready` = 1 for one cycle and `mem_req_valid` = 1.
- **Request stall:** `mem_req_valid` stays high, with `mem_*` fields stable, through any number of `mem_req_ready` = 0 cycles.
- **Response path:** `mem_resp_valid` sampled at edge M. At M+1, `*_rvalid` = 1 with data and the FSM is in IDLE.
  - A request present in cycle M+1 is arbitrated at edge M+1; its `ready` follows at M+2.
- **Minimum latency, zero-wait memory** (`mem_req_ready` and `mem_resp_valid` each high in the first cycle they are looked at): request edge N → `rvalid` at N+3. Throughput is one transaction per 3 cycles.
- **Requester hold rule:** requesters keep the address and data stable until they see `ready`.
  - A `req` still high after `ready` is treated as a new request once the FSM returns to IDLE.
- **Simultaneous requests at one edge:** only one `ready` pulses; the loser keeps waiting.
- **Wrap-around:** none. Addresses pass through unchanged except bits [2:0].

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-WAIT → all outputs 0. A later `mem_resp_valid` produces no `rvalid`. FSM is in IDLE.
- **Single fetch, zero-wait memory:** `inst_addr` = 0x80000004 at edge 0 → `inst_ready` at 1, with `mem_addr` = 0x80000000 and `mem_wen` = 0. Memory returns 0x00100093_00000013 → `inst_rvalid` at 3 with that value.
- **Store:** `data_wen` = 1, `data_addr` = 0x80001003, `data_wmask` = 0xFF000000, `data_wdata` = 0xAB000000. Memory holds `mem_req_ready` = 0 for 3 cycles → `mem_req_valid` stays high and stable. `data_rvalid` pulses once after the response.
- **Contention:** `inst_req` and `data_req` both held high continuously, zero-wait memory → grant order D,D,D,D,I,D,D,D,D,I, with `starve_cnt` reaching 4 before each I grant.
- **Back-to-back:** `data_req` re-asserted in the `data_rvalid` cycle → next `data_ready` exactly one cycle after `rvalid`.
- **Stray response:** `mem_resp_valid` pulsed while in REQ → ignored. The real response in WAIT delivers exactly one `rvalid`.
